rom_word_fetch_arb: RTL

- Two-requester controller for the byte-wide SVM coefficient ROM.
- Arbitrates word-fetch bursts between requester 0 and requester 1 using round-robin.
- Sequences four byte reads per 32-bit IEEE-754 word and assembles each word.
- Returns each word, with a last-word marker, to the granted requester. Sits between the SVM compute engines and the ROM read port.

---
 rtl/rom_word_fetch_arb_if.sv | 45 ++++
 rtl/rom_word_fetch_arb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rom_word_fetch_arb_if.sv
// Request, response and ROM read-port signals for rom_word_fetch_arb.
// The slave modport is the arbiter's view; master is the requester/ROM side.
interface rom_word_fetch_arb_if #(
   parameter int ROM_ADDR_WD = 8,
   parameter int LEN_WD      = 4
);
   logic                   req0_vld;
   logic                   req0_rdy;
   logic [ROM_ADDR_WD-3:0] req0_waddr;
   logic [LEN_WD-1:0]      req0_len;
   logic                   req1_vld;
   logic                   req1_rdy;
   logic [ROM_ADDR_WD-3:0] req1_waddr;
   logic [LEN_WD-1:0]      req1_len;
   logic                   rsp0_vld;
   logic [31:0]            rsp0_data;
   logic                   rsp0_last;
   logic                   rsp0_err;
   logic                   rsp1_vld;
   logic [31:0]            rsp1_data;
   logic                   rsp1_last;
   logic                   rsp1_err;
   logic                   rom_rd_vld;
   logic [ROM_ADDR_WD-1:0] rom_rd_addr;
   logic [7:0]             rom_rd_data;
   logic                   rom_rd_data_out_vld;

   modport slave (
      input  req0_vld, req0_waddr, req0_len, req1_vld, req1_waddr, req1_len,
      input  rom_rd_data, rom_rd_data_out_vld,
      output req0_rdy, req1_rdy,
      output rsp0_vld, rsp0_data, rsp0_last, rsp0_err,
      output rsp1_vld, rsp1_data, rsp1_last, rsp1_err,
      output rom_rd_vld, rom_rd_addr
   );

   modport master (
      output req0_vld, req0_waddr, req0_len, req1_vld, req1_waddr, req1_len,
      output rom_rd_data, rom_rd_data_out_vld,
      input  req0_rdy, req1_rdy,
      input  rsp0_vld, rsp0_data, rsp0_last, rsp0_err,
      input  rsp1_vld, rsp1_data, rsp1_last, rsp1_err,
      input  rom_rd_vld, rom_rd_addr
   );
endinterface

// File: rtl/rom_word_fetch_arb.sv
// Round-robin word-fetch arbiter for the byte-wide SVM coefficient ROM.
// Define SVM_ROM_FETCH_LITTLE_ENDIAN_EN for little-endian word assembly.
module rom_word_fetch_arb #(
   parameter int ROM_ADDR_WD = 8,
   parameter int ROM_DEPTH   = 124,
   parameter int LEN_WD      = 4
) (
   input logic                 clk,
   input logic                 reset_n,
   rom_word_fetch_arb_if.slave bus
);
   localparam int WA_WD  = ROM_ADDR_WD - 2;
   localparam int END_WD = ROM_ADDR_WD + LEN_WD + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CHECK = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]        state;
   logic              last_gnt;
   logic              gnt_q;
   logic [WA_WD-1:0]  waddr_q;
   logic [LEN_WD-1:0] len_q;
   logic [LEN_WD-1:0] word_cnt;
   logic [1:0]        byte_cnt;
   logic [LEN_WD-1:0] cap_word;
   logic [1:0]        cap_byte;
   logic [23:0]       asm_q;
   logic              rsp_vld_q;
   logic              rsp_last_q;
   logic              rsp_err_q;
   logic              rsp_sel_q;
   logic [31:0]       rsp_data_q;

   logic              gnt0;
   logic              gnt1;
   logic              accept;
   logic              range_err;
   logic              issue_done;
   logic              capture;
   logic [END_WD-1:0] end_byte;
   logic [WA_WD-1:0]  word_addr;

   function automatic logic [23:0] shift_in(input logic [23:0] part, input logic [7:0] b);
`ifdef SVM_ROM_FETCH_LITTLE_ENDIAN_EN
      return {b, part[23:8]};
`else
      return {part[15:0], b};
`endif
   endfunction

   function automatic logic [31:0] assemble(input logic [23:0] part, input logic [7:0] b);
`ifdef SVM_ROM_FETCH_LITTLE_ENDIAN_EN
      return {b, part};
`else
      return {part, b};
`endif
   endfunction

   // On contention the requester not granted last wins; rdy never rises without vld.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset_n && state == IDLE) begin
         if (bus.req0_vld && (!bus.req1_vld || last_gnt)) gnt0 = 1'b1;
         else if (bus.req1_vld)                            gnt1 = 1'b1;
      end
   end

   assign bus.req0_rdy = gnt0;
   assign bus.req1_rdy = gnt1;
   assign accept       = gnt0 | gnt1;

   assign end_byte   = (END_WD'(waddr_q) + END_WD'(len_q) + END_WD'(1)) << 2;
   assign range_err  = end_byte > END_WD'(ROM_DEPTH);
   assign word_addr  = waddr_q + WA_WD'(word_cnt);
   assign issue_done = (byte_cnt == 2'd3) && (word_cnt == len_q);
   assign capture    = bus.rom_rd_data_out_vld && (state == ISSUE || state == DRAIN);

   assign bus.rom_rd_vld  = (state == ISSUE);
   assign bus.rom_rd_addr = (state == ISSUE) ? {word_addr, byte_cnt} : '0;

   assign bus.rsp0_vld  = rsp_vld_q  & ~rsp_sel_q;
   assign bus.rsp0_last = rsp_last_q & ~rsp_sel_q;
   assign bus.rsp0_err  = rsp_err_q  & ~rsp_sel_q;
   assign bus.rsp0_data = rsp_sel_q ? 32'h0 : rsp_data_q;
   assign bus.rsp1_vld  = rsp_vld_q  & rsp_sel_q;
   assign bus.rsp1_last = rsp_last_q & rsp_sel_q;
   assign bus.rsp1_err  = rsp_err_q  & rsp_sel_q;
   assign bus.rsp1_data = rsp_sel_q ? rsp_data_q : 32'h0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_gnt   <= 1'b1;
         gnt_q      <= 1'b0;
         waddr_q    <= '0;
         len_q      <= '0;
         word_cnt   <= '0;
         byte_cnt   <= '0;
         cap_word   <= '0;
         cap_byte   <= '0;
         asm_q      <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_last_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         rsp_sel_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         rsp_vld_q  <= 1'b0;
         rsp_last_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         rsp_data_q <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  waddr_q  <= gnt1 ? bus.req1_waddr : bus.req0_waddr;
                  len_q    <= gnt1 ? bus.req1_len   : bus.req0_len;
                  gnt_q    <= gnt1;
                  last_gnt <= gnt1;
                  word_cnt <= '0;
                  byte_cnt <= '0;
                  cap_word <= '0;
                  cap_byte <= '0;
                  asm_q    <= '0;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               if (range_err) begin
                  rsp_vld_q  <= 1'b1;
                  rsp_last_q <= 1'b1;
                  rsp_err_q  <= 1'b1;
                  rsp_sel_q  <= gnt_q;
                  state      <= IDLE;
               end else begin
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               byte_cnt <= byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) word_cnt <= word_cnt + 1'b1;
               if (issue_done) state <= DRAIN;
            end
            DRAIN: begin
               if (rsp_vld_q && rsp_last_q) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // The fourth byte goes straight into the response register so the word leaves one cycle after it lands.
         if (capture) begin
            cap_byte <= cap_byte + 2'd1;
            if (cap_byte == 2'd3) begin
               rsp_vld_q  <= 1'b1;
               rsp_data_q <= assemble(asm_q, bus.rom_rd_data);
               rsp_last_q <= (cap_word == len_q);
               rsp_sel_q  <= gnt_q;
               cap_word   <= cap_word + 1'b1;
               asm_q      <= '0;
            end else begin
               asm_q <= shift_in(asm_q, bus.rom_rd_data);
            end
         end
      end
   end
endmodule
